// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI stream slave.
package spi_pkg;

  // Frame state: IDLE while cs_n is high, FRAME while a transfer is selected.
  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Edge roles, indexed by the latched cpha value: which sclk edge samples mosi.
  // The other edge of the pair is the shift edge.
  localparam logic SAMPLE_ON_LEADING  = 1'b0;
  localparam logic SAMPLE_ON_TRAILING = 1'b1;

  // Bit counter width: must hold the values 0..data_width.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI input.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Shift the raw input through the flop chain; reset to the line's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with valid/ready word streams, all four SPI modes, one-entry TX
// holding register, sticky underrun/overrun flags and mid-word abort detection.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  output logic                  frame_abort,
  input  logic                  status_clr
);

  localparam int CW = cnt_width(DATA_WIDTH);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_reg, cs_n_prev_reg;
  logic [SYNC_STAGES-1:0] flush_reg;
  logic armed_reg;
  state_t state_reg, state_next;
  logic cpol_reg, cpha_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [DATA_WIDTH-1:0] tx_shift_reg, hold_reg, rx_shift_reg, rx_data_reg;
  logic hold_full_reg, rx_valid_reg, tx_underrun_reg, rx_overrun_reg, frame_abort_reg;

  logic cs_fall, cs_rise, frame_start, frame_end, active;
  logic lead_edge, trail_edge, sample_edge, shift_edge, last_sample, load;
  logic tx_accept, rx_handshake, tx_bit;
  logic [DATA_WIDTH-1:0] rx_word, tx_load_word, tx_shifted;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  // Edge detection on the synchronised lines.
  assign cs_fall     = cs_n_prev_reg & ~cs_n_s;
  assign cs_rise     = ~cs_n_prev_reg & cs_n_s;
  // A frame may only start once cs_n has been genuinely seen high after reset,
  // so a cs_n that stayed low through reset is not mistaken for a fresh fall.
  assign frame_start = (state_reg == IDLE) && cs_fall && armed_reg;
  assign frame_end   = (state_reg == FRAME) && cs_rise;
  assign active      = (state_reg == FRAME) && !cs_rise;
  assign lead_edge   = active && (sclk_prev_reg == cpol_reg) && (sclk_s != cpol_reg);
  assign trail_edge  = active && (sclk_prev_reg != cpol_reg) && (sclk_s == cpol_reg);
  assign sample_edge = (cpha_reg == SAMPLE_ON_TRAILING) ? trail_edge : lead_edge;
  assign shift_edge  = (cpha_reg == SAMPLE_ON_TRAILING) ? lead_edge : trail_edge;
  assign last_sample = sample_edge && (bit_cnt_reg == CW'(DATA_WIDTH - 1));

  // A shift edge with the counter at zero is the first shift of a new word:
  // cpha=1 loads before its first sample, cpha=0 loads after the previous
  // word's last sample. cpha=0 also preloads the first word at frame start.
  assign load = (frame_start && (cpha == SAMPLE_ON_LEADING)) ||
                (shift_edge && (bit_cnt_reg == '0));

  assign rx_word      = (MSB_FIRST != 0) ? {rx_shift_reg[DATA_WIDTH-2:0], mosi_s}
                                         : {mosi_s, rx_shift_reg[DATA_WIDTH-1:1]};
  assign tx_shifted   = (MSB_FIRST != 0) ? {tx_shift_reg[DATA_WIDTH-2:0], 1'b0}
                                         : {1'b0, tx_shift_reg[DATA_WIDTH-1:1]};
  assign tx_bit       = (MSB_FIRST != 0) ? tx_shift_reg[DATA_WIDTH-1] : tx_shift_reg[0];
  assign tx_load_word = hold_full_reg ? hold_reg : '0;
  assign tx_accept    = tx_valid && !hold_full_reg;
  assign rx_handshake = rx_valid_reg && rx_ready;

  // Previous synchronised levels, plus arming once the synchroniser has flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_reg <= 1'b0;
      cs_n_prev_reg <= 1'b1;
      flush_reg     <= '0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_n_prev_reg <= cs_n_s;
      flush_reg     <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
      if (flush_reg[SYNC_STAGES-1] && cs_n_s) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: enter on an armed cs_n fall, leave on cs_n rise.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start) state_next = FRAME;
      FRAME:   if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Mode latch and bit counter; the mode is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_reg    <= 1'b0;
      cpha_reg    <= 1'b0;
      bit_cnt_reg <= '0;
    end else begin
      if (frame_start) begin
        cpol_reg <= cpol;
        cpha_reg <= cpha;
      end
      if (frame_start || frame_end) begin
        bit_cnt_reg <= '0;
      end else if (sample_edge) begin
        bit_cnt_reg <= last_sample ? '0 : bit_cnt_reg + CW'(1);
      end
    end
  end

  // TX path: holding register, shift register and underrun flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_reg    <= '0;
      hold_reg        <= '0;
      hold_full_reg   <= 1'b0;
      tx_underrun_reg <= 1'b0;
    end else begin
      if (status_clr) begin
        tx_underrun_reg <= 1'b0;
      end
      if (load) begin
        tx_shift_reg  <= tx_load_word;
        hold_full_reg <= 1'b0;
        if (!hold_full_reg) begin
          tx_underrun_reg <= 1'b1;
        end
      end else if (frame_start) begin
        // cpha=1 has nothing to drive until its first leading edge.
        tx_shift_reg <= '0;
      end else if (shift_edge) begin
        tx_shift_reg <= tx_shifted;
      end
      if (tx_accept) begin
        hold_reg      <= tx_data;
        hold_full_reg <= 1'b1;
      end
    end
  end

  // RX path: shift in on sample edges, publish whole words, flag overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_reg    <= '0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
    end else begin
      if (sample_edge) begin
        rx_shift_reg <= rx_word;
      end
      if (status_clr) begin
        rx_overrun_reg <= 1'b0;
      end
      if (last_sample) begin
        rx_data_reg  <= rx_word;
        rx_valid_reg <= 1'b1;
        if (rx_valid_reg && !rx_ready) begin
          rx_overrun_reg <= 1'b1;
        end
      end else if (rx_handshake) begin
        rx_valid_reg <= 1'b0;
      end
      frame_abort_reg <= frame_end && (bit_cnt_reg != '0);
    end
  end

  assign busy        = (state_reg == FRAME);
  assign miso_oe     = busy;
  assign miso        = busy ? tx_bit : 1'b0;
  assign tx_ready    = !hold_full_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = tx_underrun_reg;
  assign rx_overrun  = rx_overrun_reg;
  assign frame_abort = frame_abort_reg;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: instance 0 is MSB-first, instance 1 LSB-first.
// A bench-side SPI master drives frames; expected miso/rx words come from the
// words the bench queued and sent, plus a count of word loads per frame.
module tb_spi_slave_stream;

  localparam int DW   = 8;
  localparam int HALF = 8;  // clk cycles per sclk half period

  logic clk = 1'b0;
  logic rst_n, cpol, cpha, sclk, mosi, status_clr;
  logic cs_n [2];
  logic tx_valid [2];
  logic [DW-1:0] tx_data [2];
  logic rx_ready [2];
  logic miso [2], miso_oe [2], tx_ready [2], rx_valid [2], busy [2];
  logic tx_underrun [2], rx_overrun [2], frame_abort [2];
  logic [DW-1:0] rx_data [2];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] txq [2][$];
  logic [DW-1:0] rxcap [2][$];
  int abort_cnt [2];
  int rxv_cycles [2];
  logic [DW-1:0] mosi_words [$];
  logic [DW-1:0] miso_cap [$];
  logic [DW-1:0] tx_words [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_slave_stream #(
      .DATA_WIDTH(DW), .MSB_FIRST(gi == 0 ? 1 : 0), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .cs_n(cs_n[gi]), .mosi(mosi),
      .miso(miso[gi]), .miso_oe(miso_oe[gi]),
      .tx_data(tx_data[gi]), .tx_valid(tx_valid[gi]), .tx_ready(tx_ready[gi]),
      .rx_data(rx_data[gi]), .rx_valid(rx_valid[gi]), .rx_ready(rx_ready[gi]),
      .busy(busy[gi]), .tx_underrun(tx_underrun[gi]), .rx_overrun(rx_overrun[gi]),
      .frame_abort(frame_abort[gi]), .status_clr(status_clr)
    );
  end

  // Main-process changes land 1 ns after the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // TX feeder: offers the head of each queue; pops once the handshake is seen.
  initial begin
    bit pend [2];
    for (int s = 0; s < 2; s++) begin
      tx_valid[s] = 1'b0;
      tx_data[s]  = '0;
      pend[s]     = 1'b0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int s = 0; s < 2; s++) begin
        if (pend[s]) void'(txq[s].pop_front());
        pend[s] = 1'b0;
        if (txq[s].size() > 0) begin
          tx_valid[s] = 1'b1;
          tx_data[s]  = txq[s][0];
          pend[s]     = tx_ready[s] && rst_n;
        end else begin
          tx_valid[s] = 1'b0;
          tx_data[s]  = '0;
        end
      end
    end
  end

  // RX / abort monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int s = 0; s < 2; s++) begin
        if (rx_valid[s] && rx_ready[s]) rxcap[s].push_back(rx_data[s]);
        if (rx_valid[s]) rxv_cycles[s]++;
        if (frame_abort[s]) abort_cnt[s]++;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One SPI frame from the bench master to instance sel. stop_bits>0 ends early;
  // leave_cs_low skips the cs_n release at the end.
  task automatic run_frame(input int sel, input logic pol, input logic pha, input int nwords,
                           input int stop_bits, input bit leave_cs_low);
    int total;
    logic [DW-1:0] w, cur;
    logic mbit;
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    foreach (tx_words[k]) txq[sel].push_back(tx_words[k]);
    tick(4);
    abort_cnt[sel] = 0;
    rxv_cycles[sel] = 0;
    rxcap[sel].delete();
    miso_cap.delete();
    cpol = pol;
    cpha = pha;
    sclk = pol;
    mosi = 1'b0;
    tick(HALF);
    cs_n[sel] = 1'b0;
    tick(HALF);
    total = (stop_bits > 0) ? stop_bits : nwords * DW;
    cur = '0;
    for (int b = 0; b < total; b++) begin
      int k, i;
      k = b / DW;
      i = b % DW;
      w = mosi_words[k];
      if (!pha) begin
        mosi = (sel == 0) ? w[DW-1-i] : w[i];
        tick(HALF);
        mbit = miso[sel];
        sclk = ~pol;
        tick(HALF);
        sclk = pol;
      end else begin
        sclk = ~pol;
        mosi = (sel == 0) ? w[DW-1-i] : w[i];
        tick(HALF);
        mbit = miso[sel];
        sclk = pol;
        tick(HALF);
      end
      if (sel == 0) cur = {cur[DW-2:0], mbit};
      else          cur[i] = mbit;
      if (i == DW - 1) begin
        miso_cap.push_back(cur);
        cur = '0;
      end
      if (b == 1) begin
        checks++;
        if (busy[sel] !== 1'b1 || miso_oe[sel] !== 1'b1)
          $display("FAIL busy_in_frame: busy=%b miso_oe=%b required 1/1", busy[sel], miso_oe[sel]);
        if (busy[sel] !== 1'b1 || miso_oe[sel] !== 1'b1) errors++;
      end
    end
    if (!pha) tick(HALF);
    if (!leave_cs_low) begin
      cs_n[sel] = 1'b1;
      tick(HALF);
    end
  endtask

  // Compare one completed frame against the queued/sent words.
  task automatic check_frame(input int sel, input logic pha, input int nwords, input string name);
    int loads;
    logic [DW-1:0] exp_w;
    logic exp_ur;
    loads = nwords + (pha ? 0 : 1);
    for (int k = 0; k < nwords; k++) begin
      exp_w = (k < tx_words.size()) ? tx_words[k] : '0;
      checks++;
      if (k >= miso_cap.size() || miso_cap[k] !== exp_w) begin
        errors++;
        $display("FAIL %s miso word %0d: got %h required %h", name, k,
                 (k < miso_cap.size()) ? miso_cap[k] : 'x, exp_w);
      end
    end
    checks++;
    if (rxcap[sel].size() != nwords) begin
      errors++;
      $display("FAIL %s rx count: got %0d required %0d", name, rxcap[sel].size(), nwords);
    end else begin
      for (int k = 0; k < nwords; k++) begin
        checks++;
        if (rxcap[sel][k] !== mosi_words[k]) begin
          errors++;
          $display("FAIL %s rx word %0d: got %h required %h", name, k, rxcap[sel][k], mosi_words[k]);
        end
      end
    end
    exp_ur = (loads > tx_words.size());
    checks++;
    if (tx_underrun[sel] !== exp_ur) begin
      errors++;
      $display("FAIL %s tx_underrun: got %b required %b", name, tx_underrun[sel], exp_ur);
    end
    checks++;
    if (rx_overrun[sel] !== 1'b0 || abort_cnt[sel] != 0) begin
      errors++;
      $display("FAIL %s overrun/abort: got %b/%0d required 0/0", name, rx_overrun[sel], abort_cnt[sel]);
    end
    $display("frame %s sel=%0d cpha=%b words=%0d done", name, sel, pha, nwords);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({miso[s], miso_oe[s], tx_ready[s], rx_valid[s], busy[s], tx_underrun[s],
           rx_overrun[s], frame_abort[s]} !== 8'b0010_0000 || rx_data[s] !== '0) begin
        errors++;
        $display("FAIL %s inst%0d: got flags %b data %h required 00100000 data 00", name, s,
                 {miso[s], miso_oe[s], tx_ready[s], rx_valid[s], busy[s], tx_underrun[s],
                  rx_overrun[s], frame_abort[s]}, rx_data[s]);
      end
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'($urandom);
  endfunction

  task automatic test_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_mode0();
    tx_words = '{8'hA5, rnd_word()};
    mosi_words = '{8'h3C};
    run_frame(0, 1'b0, 1'b0, 1, 0, 1'b0);
    check_frame(0, 1'b0, 1, "mode0");
    checks++;
    if (rxv_cycles[0] != 1) begin
      errors++;
      $display("FAIL mode0 rx_valid pulse: got %0d cycles required 1", rxv_cycles[0]);
    end
  endtask

  task automatic test_modes_lsb();
    for (int m = 1; m < 4; m++) begin
      logic pol, pha;
      pol = m[1];
      pha = m[0];
      tx_words = pha ? '{8'h0F} : '{8'h0F, rnd_word()};
      mosi_words = '{8'h81};
      run_frame(1, pol, pha, 1, 0, 1'b0);
      check_frame(1, pha, 1, $sformatf("lsb_mode%0d", m));
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic pol, pha;
    pol = 1'($urandom_range(0, 1));
    pha = 1'($urandom_range(0, 1));
    tx_words.delete();
    mosi_words.delete();
    for (int k = 0; k < 3; k++) mosi_words.push_back(rnd_word());
    for (int k = 0; k < (pha ? 3 : 4); k++) tx_words.push_back(rnd_word());
    rx_ready[0] = 1'b0;
    run_frame(0, pol, pha, 3, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (miso_cap[k] !== tx_words[k]) begin
        errors++;
        $display("FAIL b2b miso word %0d: got %h required %h", k, miso_cap[k], tx_words[k]);
      end
    end
    checks++;
    if (rx_data[0] !== mosi_words[2] || rx_valid[0] !== 1'b1 || rx_overrun[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b overrun: got data %h valid %b ovr %b required %h 1 1",
               rx_data[0], rx_valid[0], rx_overrun[0], mosi_words[2]);
    end
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    checks++;
    if (rx_overrun[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b status_clr: got rx_overrun %b required 0", rx_overrun[0]);
    end
    rx_ready[0] = 1'b1;
    tick(3);
    checks++;
    if (rx_valid[0] !== 1'b0 || rxcap[0].size() != 1 || rxcap[0][0] !== mosi_words[2]) begin
      errors++;
      $display("FAIL b2b drain: got valid %b count %0d required 0 1", rx_valid[0], rxcap[0].size());
    end
    $display("frame b2b_overrun cpol=%b cpha=%b words=3 done", pol, pha);
  endtask

  task automatic test_underrun();
    tx_words.delete();
    mosi_words = '{rnd_word()};
    run_frame(0, 1'b0, 1'b0, 1, 0, 1'b0);
    check_frame(0, 1'b0, 1, "underrun_mode0");
    mosi_words = '{rnd_word()};
    run_frame(1, 1'b1, 1'b1, 1, 0, 1'b0);
    check_frame(1, 1'b1, 1, "underrun_mode3");
  endtask

  task automatic test_abort();
    tx_words.delete();
    mosi_words = '{rnd_word()};
    run_frame(0, 1'b0, 1'b0, 1, 5, 1'b0);
    checks++;
    if (abort_cnt[0] != 1 || rx_valid[0] !== 1'b0 || rxcap[0].size() != 0) begin
      errors++;
      $display("FAIL abort: got pulses %0d rx_valid %b words %0d required 1 0 0",
               abort_cnt[0], rx_valid[0], rxcap[0].size());
    end
    $display("frame abort after 5 bits done");
    tx_words = '{rnd_word(), rnd_word()};
    mosi_words = '{rnd_word()};
    run_frame(0, 1'b0, 1'b0, 1, 0, 1'b0);
    check_frame(0, 1'b0, 1, "after_abort");
  endtask

  task automatic test_reset_midframe();
    tx_words.delete();
    mosi_words = '{rnd_word()};
    run_frame(0, 1'b0, 1'b0, 1, 4, 1'b1);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("reset_midframe");
    rst_n = 1'b1;
    tick(2 * HALF);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_idle: got busy %b required 0", busy[0]);
    end
    cs_n[0] = 1'b1;
    tick(HALF);
    checks++;
    if (abort_cnt[0] != 0) begin
      errors++;
      $display("FAIL reset_no_abort: got pulses %0d required 0", abort_cnt[0]);
    end
    tx_words = '{rnd_word(), rnd_word()};
    mosi_words = '{rnd_word()};
    run_frame(0, 1'b0, 1'b0, 1, 0, 1'b0);
    check_frame(0, 1'b0, 1, "after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int sel, nw, ntx;
      logic pol, pha;
      sel = $urandom_range(0, 1);
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      ntx = nw + (pha ? 0 : 1) - (($urandom_range(0, 3) == 0) ? 1 : 0);
      tx_words.delete();
      mosi_words.delete();
      for (int k = 0; k < ntx; k++) tx_words.push_back(rnd_word());
      for (int k = 0; k < nw; k++) mosi_words.push_back(rnd_word());
      run_frame(sel, pol, pha, nw, 0, 1'b0);
      check_frame(sel, pha, nw, $sformatf("random%0d_cpol%0d", f, pol));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    status_clr = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cs_n[s] = 1'b1;
      rx_ready[s] = 1'b1;
      abort_cnt[s] = 0;
      rxv_cycles[s] = 0;
    end
    test_reset();
    test_mode0();
    test_modes_lsb();
    test_back_to_back_overrun();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
